// File: rtl/current_ctrl_pkg.sv
// Shared definitions for the current-source control path: FSM state type, default sizing and
// the request clamp reused by the loop controller.
package current_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RAMP
  } cs_state_e;

  localparam int unsigned DefaultNumSrc  = 32;
  localparam int unsigned DefaultStepDiv = 4;
  // Wide enough for the largest supported step divider (255).
  localparam int unsigned StepTimerW     = 8;

  function automatic int unsigned clamp_count(input int unsigned req,
                                              input int unsigned limit,
                                              input int unsigned num_src);
    int unsigned m;
    m = (req < limit) ? req : limit;
    return (m < num_src) ? m : num_src;
  endfunction

endpackage

// File: rtl/cs_step_timer.sv
// Step pacing down-counter: load sets the count, en decrements it, tick_o flags a zero count
// while enabled.
module cs_step_timer
  import current_ctrl_pkg::*;
#(
  parameter int unsigned Width = StepTimerW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tick_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = en_i && (count_q == '0);

endmodule

// File: rtl/current_source_ramp_driver.sv
// Slew-limited current-source enable driver: walks the enable window one source per step toward
// a clamped target. Define CS_ROTATE_EN to rotate the window start (dynamic element matching).
module current_source_ramp_driver
  import current_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC  = DefaultNumSrc,
  parameter int unsigned CNT_W    = $clog2(NUM_SRC + 1),
  parameter int unsigned STEP_DIV = DefaultStepDiv
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [CNT_W-1:0]   TARGET_COUNT,
  input  logic               TARGET_VALID,
  output logic               TARGET_READY,
  input  logic [CNT_W-1:0]   SRC_LIMIT,
  output logic [NUM_SRC-1:0] CURRENT_SOURCE_ENABLE,
  output logic [CNT_W-1:0]   ENABLED_COUNT,
  output logic               BUSY,
  output logic               SETTLED
);

  localparam logic [StepTimerW-1:0] Reload = StepTimerW'(STEP_DIV - 1);
  localparam logic [NUM_SRC-1:0]    One    = {{(NUM_SRC - 1){1'b0}}, 1'b1};

  // Index add with wrap at NUM_SRC; one spare bit keeps the sum exact for non-power-of-two sizes.
  function automatic logic [CNT_W-1:0] wrap_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (CNT_W + 1)'(NUM_SRC)) begin
      sum = sum - (CNT_W + 1)'(NUM_SRC);
    end
    return CNT_W'(sum);
  endfunction

  cs_state_e          state_q, state_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic               settled_q, settled_d;
  logic [CNT_W-1:0]   head;

  logic               accept;
  logic [CNT_W-1:0]   tgt_new;
  logic               tick;
  logic               step, step_up, step_dn;
  logic [CNT_W-1:0]   cnt_step;
  logic [CNT_W-1:0]   idx_up, idx_dn;

  assign accept   = TARGET_VALID && TARGET_READY;
  assign tgt_new  = CNT_W'(clamp_count(32'(TARGET_COUNT), 32'(SRC_LIMIT), NUM_SRC));
  assign step     = (state_q == ST_RAMP) && tick;
  assign step_up  = step && (cnt_q < tgt_q);
  assign step_dn  = step && !(cnt_q < tgt_q);
  assign cnt_step = step_up ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
  assign idx_up   = wrap_add(head, cnt_q);

`ifdef CS_ROTATE_EN
  logic [CNT_W-1:0] head_q, head_d;

  always_comb begin
    head_d = head_q;
    if (step_dn) begin
      head_d = wrap_add(head_q, CNT_W'(1));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q <= '0;
    end else begin
      head_q <= head_d;
    end
  end

  assign head   = head_q;
  assign idx_dn = head_q;
`else
  assign head   = '0;
  assign idx_dn = cnt_q - 1'b1;
`endif

  cs_step_timer #(
    .Width(StepTimerW)
  ) u_step_timer (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .load_i    ((accept && (tgt_new != cnt_q)) || step),
    .load_val_i(Reload),
    .en_i      (state_q == ST_RAMP),
    .tick_o    (tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && (tgt_new != cnt_q)) state_d = ST_RAMP;
      ST_RAMP: if (step && (cnt_step == tgt_q)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    TARGET_READY = (state_q == ST_IDLE);
    BUSY         = (state_q == ST_RAMP);
  end

  // Each step touches exactly one enable bit, so the array never sees a multi-source step.
  always_comb begin
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    settled_d = 1'b0;
    if (accept) begin
      tgt_d = tgt_new;
      if (tgt_new == cnt_q) settled_d = 1'b1;
    end
    if (step) begin
      cnt_d = cnt_step;
      if (step_up) begin
        en_d = en_q | (One << idx_up);
      end else begin
        en_d = en_q & ~(One << idx_dn);
      end
      if (cnt_step == tgt_q) settled_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tgt_q     <= '0;
      cnt_q     <= '0;
      en_q      <= '0;
      settled_q <= 1'b0;
    end else begin
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      settled_q <= settled_d;
    end
  end

  assign CURRENT_SOURCE_ENABLE = en_q;
  assign ENABLED_COUNT         = cnt_q;
  assign SETTLED               = settled_q;

endmodule

// File: tb/tb_current_source_ramp_driver.sv
// Scoreboard bench for current_source_ramp_driver: each request pushes its expected enable
// steps; a monitor pops one entry per observed enable change or SETTLED pulse.
module tb_current_source_ramp_driver;

  localparam int NumSrc  = 32;
  localparam int CntW    = 6;
  localparam int StepDiv = 4;

  logic              CLK;
  logic              RST_N;
  logic [CntW-1:0]   TARGET_COUNT;
  logic              TARGET_VALID;
  logic              TARGET_READY;
  logic [CntW-1:0]   SRC_LIMIT;
  logic [NumSrc-1:0] CURRENT_SOURCE_ENABLE;
  logic [CntW-1:0]   ENABLED_COUNT;
  logic              BUSY;
  logic              SETTLED;

  current_source_ramp_driver #(
    .NUM_SRC (NumSrc),
    .CNT_W   (CntW),
    .STEP_DIV(StepDiv)
  ) dut (
    .CLK                  (CLK),
    .RST_N                (RST_N),
    .TARGET_COUNT         (TARGET_COUNT),
    .TARGET_VALID         (TARGET_VALID),
    .TARGET_READY         (TARGET_READY),
    .SRC_LIMIT            (SRC_LIMIT),
    .CURRENT_SOURCE_ENABLE(CURRENT_SOURCE_ENABLE),
    .ENABLED_COUNT        (ENABLED_COUNT),
    .BUSY                 (BUSY),
    .SETTLED              (SETTLED)
  );

  typedef struct {
    int          cyc;
    logic [31:0] en;
    logic [5:0]  cnt;
    logic        settled;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          busy_cycles = 0;
  int          settled_cnt = 0;
  bit          mon_en = 0;
  logic [31:0] prev_en = '0;

  // Reference model state.
  logic [31:0] m_en = '0;
  int          m_cnt = 0;
  int          m_head = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (!TARGET_READY) busy_cycles++;
      if (SETTLED) settled_cnt++;
      if ((CURRENT_SOURCE_ENABLE != prev_en) || SETTLED) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 64'(sb.size()), 64'(1));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("en", 64'(CURRENT_SOURCE_ENABLE), 64'(e.en));
          check("cnt", 64'(ENABLED_COUNT), 64'(e.cnt));
          check("settled", 64'(SETTLED), 64'(e.settled));
          check("cycle", 64'(cyc), 64'(e.cyc));
        end
        if (CURRENT_SOURCE_ENABLE != prev_en) begin
          check("one_bit", 64'($countones(CURRENT_SOURCE_ENABLE ^ prev_en)), 64'(1));
          check("popcount", 64'(ENABLED_COUNT), 64'($countones(CURRENT_SOURCE_ENABLE)));
        end
      end
      prev_en = CURRENT_SOURCE_ENABLE;
    end
  end

  task automatic model_step(input bit up);
    if (up) begin
      m_en[(m_head + m_cnt) % NumSrc] = 1'b1;
      m_cnt++;
    end else begin
`ifdef CS_ROTATE_EN
      m_en[m_head] = 1'b0;
      m_head = (m_head + 1) % NumSrc;
`else
      m_en[m_cnt - 1] = 1'b0;
`endif
      m_cnt--;
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2000 && !TARGET_READY; i++) @(negedge CLK);
    check("ready_wait", 64'(TARGET_READY), 64'(1));
  endtask

  task automatic request(input int req, input int lim);
    int   k;
    int   tgt;
    int   n;
    bit   up;
    exp_t e;
    wait_ready();
    @(negedge CLK);
    busy_cycles = 0;
    settled_cnt = 0;
    TARGET_COUNT = CntW'(req);
    SRC_LIMIT    = CntW'(lim);
    TARGET_VALID = 1'b1;
    @(posedge CLK);
    #1;
    k = cyc;
    TARGET_VALID = 1'b0;
    tgt = (req < lim) ? req : lim;
    if (tgt > NumSrc) tgt = NumSrc;
    if (tgt == m_cnt) begin
      // Zero delta: SETTLED in the cycle right after the handshake edge.
      e = '{cyc: k, en: m_en, cnt: 6'(m_cnt), settled: 1'b1};
      sb.push_back(e);
    end else begin
      up = (tgt > m_cnt);
      n  = up ? (tgt - m_cnt) : (m_cnt - tgt);
      for (int i = 1; i <= n; i++) begin
        model_step(up);
        e = '{cyc: k + i * StepDiv, en: m_en, cnt: 6'(m_cnt), settled: (i == n)};
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if ((sb.size() == 0) && TARGET_READY) break;
    end
    @(negedge CLK);
    check("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"}, 64'(CURRENT_SOURCE_ENABLE), 64'(0));
    check({tag, "_cnt"}, 64'(ENABLED_COUNT), 64'(0));
    check({tag, "_ready"}, 64'(TARGET_READY), 64'(1));
    check({tag, "_busy"}, 64'(BUSY), 64'(0));
    check({tag, "_settled"}, 64'(SETTLED), 64'(0));
  endtask

  initial begin
    RST_N        = 1'b0;
    TARGET_COUNT = '0;
    TARGET_VALID = 1'b0;
    SRC_LIMIT    = 6'd32;
    repeat (2) @(negedge CLK);
    check_idle("rst");
    RST_N = 1'b1;
    @(negedge CLK);
    check_idle("post_rst");
    prev_en = CURRENT_SOURCE_ENABLE;
    mon_en  = 1'b1;

    // 0 -> 5: five steps, four clocks apart.
    request(5, 32);
    wait_done();
    check("up5_en", 64'(CURRENT_SOURCE_ENABLE), 64'h1F);
    check("up5_busy_cycles", 64'(busy_cycles), 64'(20));
    check("up5_settled_pulses", 64'(settled_cnt), 64'(1));

    // 5 -> 2.
    request(2, 32);
    wait_done();
`ifdef CS_ROTATE_EN
    check("dn2_en", 64'(CURRENT_SOURCE_ENABLE), 64'h18);
    check("dn2_head", 64'(dut.head_q), 64'(3));
`else
    check("dn2_en", 64'(CURRENT_SOURCE_ENABLE), 64'h03);
`endif
    check("dn2_cnt", 64'(ENABLED_COUNT), 64'(2));

    // Clamp: 40 requested, limit 10.
    request(40, 10);
    wait_done();
    check("clamp_cnt", 64'(ENABLED_COUNT), 64'(10));
    check("clamp_pop", 64'($countones(CURRENT_SOURCE_ENABLE)), 64'(10));

    // Zero delta.
    request(10, 32);
    wait_done();
    check("zero_busy_cycles", 64'(busy_cycles), 64'(0));
    check("zero_settled_pulses", 64'(settled_cnt), 64'(1));
    check("zero_cnt", 64'(ENABLED_COUNT), 64'(10));

    // Reset while ramping down through 7.
    request(0, 32);
    for (int i = 0; i < 200 && ENABLED_COUNT != 6'd7; i++) @(negedge CLK);
    check("reach7", 64'(ENABLED_COUNT), 64'(7));
    #2;
    mon_en = 1'b0;
    RST_N  = 1'b0;
    #1;
    check_idle("mid_rst");
    sb.delete();
    m_en   = '0;
    m_cnt  = 0;
    m_head = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle("rel_rst");
    prev_en = CURRENT_SOURCE_ENABLE;
    mon_en  = 1'b1;

    // Full-scale swings; the rotating window wraps its head through 31 -> 0.
    for (int r = 0; r < 3; r++) begin
      request(32, 32);
      wait_done();
      check("full_en", 64'(CURRENT_SOURCE_ENABLE), 64'hFFFF_FFFF);
      request(0, 32);
      wait_done();
      check("empty_en", 64'(CURRENT_SOURCE_ENABLE), 64'(0));
`ifdef CS_ROTATE_EN
      check("wrap_head", 64'(dut.head_q), 64'(m_head));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
